acq_sequencer: RTL

Top-level acquisition sequencer for the ADQ214 capture path. On a host start command it clears the accumulator, enables capture for a programmed number of trigger pulses, then hands the finished group to the upload engine and waits for completion. In continuous mode it repeats groups until the host issues stop. A trigger watchdog aborts a group when the laser trigger disappears.

---
 rtl/acq_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/acq_sequencer.sv
// rtl/acq_sequencer.sv - acquisition group sequencer with trigger watchdog and upload handoff
module acq_sequencer #(
  parameter logic [31:0] TRIG_TIMEOUT = 32'd25_000_000,
  parameter int          GROUP_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        UR_CMD,
  input  logic [GROUP_W-1:0] TOTAL_PULSE,
  input  logic               trig_pulse,
  input  logic               upload_ready,
  input  logic               upload_done,
  output logic               Capture_En,
  output logic               accum_clear,
  output logic               upload_start,
  output logic [GROUP_W-1:0] Pulse_counts,
  output logic [GROUP_W-1:0] group_count,
  output logic               busy,
  output logic               timeout_err,
  output logic [2:0]         seq_state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_WAIT_UL = 3'd3;
  localparam logic [2:0] S_UPLOAD  = 3'd4;

  localparam logic [GROUP_W-1:0] ONE = GROUP_W'(1);

  logic [1:0]         prev;
  logic               start_edge;
  logic               stop_edge;
  logic               stop_pend;
  logic [GROUP_W-1:0] tot_reg;
  logic [31:0]        wd;
  logic               wd_expired;
  logic               last_trig;
  logic [2:0]         nxt;
  logic               unused_cmd;

  // Command bits above continuous mode carry no meaning here.
  assign unused_cmd = &{1'b0, UR_CMD[15:3]};

  assign start_edge = UR_CMD[0] & ~prev[0];
  assign stop_edge  = UR_CMD[1] & ~prev[1];
  assign wd_expired = (TRIG_TIMEOUT != 32'd0) && (wd == TRIG_TIMEOUT - 32'd1);
  assign last_trig  = (Pulse_counts + ONE) == tot_reg;

  // Next-state decision; a stop edge overrides everything except the upload_done exit.
  always_comb begin
    nxt = seq_state;
    case (seq_state)
      S_IDLE: begin
        if (start_edge && !stop_edge) nxt = S_CLEAR;
      end
      S_CLEAR: begin
        nxt = stop_edge ? S_IDLE : S_CAPTURE;
      end
      S_CAPTURE: begin
        if (stop_edge)                   nxt = S_IDLE;
        else if (trig_pulse && last_trig) nxt = S_WAIT_UL;
        else if (!trig_pulse && wd_expired) nxt = S_IDLE;
      end
      S_WAIT_UL: begin
        if (stop_edge)         nxt = S_IDLE;
        else if (upload_ready) nxt = S_UPLOAD;
      end
      S_UPLOAD: begin
        if (upload_done)
          nxt = (UR_CMD[2] && !stop_edge && !stop_pend) ? S_CLEAR : S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // State, counters and registered outputs, all derived from the next state so they move together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev         <= 2'b00;
      seq_state    <= S_IDLE;
      stop_pend    <= 1'b0;
      tot_reg      <= '0;
      wd           <= 32'd0;
      Capture_En   <= 1'b0;
      accum_clear  <= 1'b0;
      upload_start <= 1'b0;
      Pulse_counts <= '0;
      group_count  <= '0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      prev         <= UR_CMD[1:0];
      seq_state    <= nxt;
      Capture_En   <= (nxt == S_CAPTURE);
      accum_clear  <= (nxt == S_CLEAR);
      busy         <= (nxt != S_IDLE);
      upload_start <= (seq_state == S_WAIT_UL) && (nxt == S_UPLOAD);

      case (seq_state)
        S_IDLE: begin
          if (nxt == S_CLEAR) begin
            group_count <= '0;
            timeout_err <= 1'b0;
          end
        end
        S_CLEAR: begin
          if (!stop_edge) begin
            Pulse_counts <= '0;
            tot_reg      <= (TOTAL_PULSE == '0) ? ONE : TOTAL_PULSE;
            wd           <= 32'd0;
          end
        end
        S_CAPTURE: begin
          if (!stop_edge) begin
            if (trig_pulse) begin
              Pulse_counts <= Pulse_counts + ONE;
              wd           <= 32'd0;
            end else begin
              wd <= wd + 32'd1;
              if (wd_expired) timeout_err <= 1'b1;
            end
          end
        end
        S_UPLOAD: begin
          if (upload_done)    group_count <= group_count + ONE;
          else if (stop_edge) stop_pend   <= 1'b1;
        end
        default: ;
      endcase

      if (nxt == S_IDLE) stop_pend <= 1'b0;
    end
  end

endmodule
